uart_alu_ctrl: RTL and testbench
================================

# uart_alu_ctrl

Multi-byte framed command controller between the UART receiver/transmitter and the ALU. It generalises the single-byte operand interface to operands of NB_DATA bits, carried as NB_DATA/8 bytes each. Frames start with a sync byte and are guarded by an inter-byte timeout. Each response is a status byte carrying the ALU flags, followed by the result bytes. It sits in the top level between rx_mod/tx_mod and alu, all on the 50 MHz clock.

## Interface
- NB_DATA, 16, ALU operand/result width; multiple of 8, minimum 8; NBYTES = NB_DATA/8
- NB_ALU_OP, 6, ALU opcode width, at most 8
- SYNC_BYTE, 8'hA5, frame start marker
- TIMEOUT_CYCLES, 1_000_000, inter-byte timeout in i_clk cycles (20 ms at 50 MHz)
- NB_TIMEOUT, 20, timeout counter width; 2^NB_TIMEOUT > TIMEOUT_CYCLES
- i_clk  in  1  system clock; one clock domain
- i_reset  in  1  asynchronous, active-low reset
- i_rx_data  in  8  received byte, valid when i_rx_done=1
- i_rx_done  in  1  one-cycle pulse per received byte
- i_tx_done  in  1  one-cycle pulse when the transmitter finishes a byte
- i_alu_res  in  NB_DATA  ALU result (combinational from o_alu_*)
- i_alu_overflow  in  1  ALU overflow flag
- i_alu_zero  in  1  ALU zero flag
- o_tx_start  out  1  one-cycle transmit request
- o_tx_data  out  8  byte to send; held stable from the o_tx_start cycle until i_tx_done
- o_alu_op  out  NB_ALU_OP  registered opcode
- o_alu_a  out  NB_DATA  registered operand A
- o_alu_b  out  NB_DATA  registered operand B
- o_busy  out  1  high in any state other than IDLE
- o_err  out  1  one-cycle pulse on a frame timeout

## Operation
- Request frame: SYNC_BYTE, OP byte (low NB_ALU_OP bits used; upper bits ignored), A bytes LSB first, B bytes LSB first. Total length is 2 + 2·NBYTES bytes.
- Response frame: STATUS byte, then result bytes LSB first. STATUS = {6'b0, overflow, zero}.
- States: IDLE, OPCODE, OPER_A, OPER_B, EXEC, SEND, WAIT_TX.
- IDLE: on i_rx_done with i_rx_data==SYNC_BYTE, go to OPCODE; any other byte is discarded silently.
- OPCODE: on i_rx_done, load o_alu_op, clear the byte counter, go to OPER_A.
- OPER_A / OPER_B: each i_rx_done writes byte[cnt] of the operand (bits 8·cnt+7:8·cnt) and increments cnt. After byte NBYTES-1, clear cnt and go to OPER_B (from OPER_A) or EXEC (from OPER_B).
- A byte equal to SYNC_BYTE inside a frame is data, not a resync.
- EXEC: a single cycle. Captures i_alu_res, i_alu_overflow and i_alu_zero into the result registers, sets tx index 0, goes to SEND.
- SEND: drive o_tx_data = STATUS for index 0, else result byte[index-1]; pulse o_tx_start; go to WAIT_TX.
- WAIT_TX: on i_tx_done, if index == NBYTES go to IDLE; otherwise increment index and go to SEND.
- i_rx_done in EXEC, SEND or WAIT_TX is ignored; the byte is lost.
- Timeout: the counter is cleared on entry to OPCODE and on every accepted byte. It increments each cycle in OPCODE, OPER_A and OPER_B. When it reaches TIMEOUT_CYCLES-1: go to IDLE, pulse o_err, clear cnt. o_alu_* keep their partial values and no response is sent.
- If a byte arrives in the same cycle the timeout expires, the timeout wins and the byte is dropped.
- No timeout applies while transmitting.
- o_alu_* hold their values between frames until overwritten.

## Timing
- Reset values: state IDLE, o_tx_start=0, o_tx_data=0, o_alu_op=0, o_alu_a=0, o_alu_b=0, o_busy=0, o_err=0, all counters 0.
- Reset is honoured mid-frame and mid-transmit. o_tx_start is never re-asserted after reset until a new complete frame arrives.
- Operand registers update on the edge that samples i_rx_done.
- Final B byte sampled at edge k: o_alu_b is complete after k and the state is EXEC. Result is captured at k+1. o_tx_start is high in the cycle after k+2 (latency of 3 edges from the final i_rx_done to the first o_tx_start).
- Next o_tx_start comes 2 cycles after each i_tx_done (WAIT_TX→SEND→WAIT_TX). One pulse per byte, NBYTES+1 pulses per frame.
- o_busy falls on the edge that samples the last i_tx_done.
- o_err lasts exactly one cycle.

## Test plan
- NB_DATA=16. Send A5 20 34 12 01 00 (ADD) -> o_alu_a=0x1234, o_alu_b=0x0001. tx bytes are 00, 35, 12 with exactly 3 o_tx_start pulses, then o_busy=0.
- Send A5 22 05 00 05 00 (SUB) -> status 01, then 00 00. Then ADD 0x7FFF+0x0001 -> status 02, then 00 80.
- Send 00 FF A5 20 01 00 02 00 -> the leading junk is ignored; response 00 03 00.
- Send A5 20 34, then stay idle for TIMEOUT_CYCLES (set to 100 in sim) -> one o_err pulse, no o_tx_start, state IDLE. The next full frame is answered correctly.
- Send a frame, then inject i_rx_done bytes during WAIT_TX -> the response is unchanged and the injected bytes have no effect.
- Assert i_reset low during the second response byte -> all outputs are at reset values immediately. No further o_tx_start occurs, and a new frame works after release.

Source files
------------

// File: rtl/uart_alu_ctrl.sv
// Framed command controller between the UART byte interface and the ALU.
// Collects SYNC/OP/A/B bytes, runs the ALU for one cycle and returns STATUS plus result bytes.
//
// state   | meaning
// IDLE    | waiting for SYNC_BYTE
// OPCODE  | waiting for the opcode byte
// OPER_A  | collecting operand A, LSB first
// OPER_B  | collecting operand B, LSB first
// EXEC    | capturing ALU result and flags
// SEND    | issuing one transmit request
// WAIT_TX | waiting for the transmitter to finish the byte
module uart_alu_ctrl #(
    parameter int             NB_DATA        = 16,
    parameter int             NB_ALU_OP      = 6,
    parameter logic [7:0]     SYNC_BYTE      = 8'hA5,
    parameter int             TIMEOUT_CYCLES = 1_000_000,
    parameter int             NB_TIMEOUT     = 20
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [7:0]           i_rx_data,
    input  logic                 i_rx_done,
    input  logic                 i_tx_done,
    input  logic [NB_DATA-1:0]   i_alu_res,
    input  logic                 i_alu_overflow,
    input  logic                 i_alu_zero,
    output logic                 o_tx_start,
    output logic [7:0]           o_tx_data,
    output logic [NB_ALU_OP-1:0] o_alu_op,
    output logic [NB_DATA-1:0]   o_alu_a,
    output logic [NB_DATA-1:0]   o_alu_b,
    output logic                 o_busy,
    output logic                 o_err
);

    localparam int NBYTES = NB_DATA / 8;
    localparam int NB_IDX = $clog2(NBYTES + 1);
    localparam logic [NB_IDX-1:0]     LAST_BYTE = NB_IDX'(NBYTES - 1);
    localparam logic [NB_IDX-1:0]     LAST_IDX  = NB_IDX'(NBYTES);
    localparam logic [NB_TIMEOUT-1:0] TMO_LAST  = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPCODE,
        ST_OPER_A,
        ST_OPER_B,
        ST_EXEC,
        ST_SEND,
        ST_WAIT_TX
    } state_t;

    state_t                  state;
    logic [NB_IDX-1:0]       byte_cnt;
    logic [NB_IDX-1:0]       tx_idx;
    logic [NB_TIMEOUT-1:0]   tmo_cnt;
    logic [NB_DATA-1:0]      res_q;
    logic                    res_ovf;
    logic                    res_zero;
    logic [7:0]              tx_byte;
    logic                    tmo_hit;

    assign tmo_hit = (tmo_cnt == TMO_LAST);

    // Index 0 is the status byte; index n carries result byte n-1.
    always_comb begin
        tx_byte = {6'b0, res_ovf, res_zero};
        for (int i = 0; i < NBYTES; i++) begin
            if (tx_idx == NB_IDX'(i + 1)) tx_byte = res_q[8*i +: 8];
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state      <= ST_IDLE;
            byte_cnt   <= '0;
            tx_idx     <= '0;
            tmo_cnt    <= '0;
            res_q      <= '0;
            res_ovf    <= 1'b0;
            res_zero   <= 1'b0;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
            o_alu_op   <= '0;
            o_alu_a    <= '0;
            o_alu_b    <= '0;
            o_busy     <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            o_err      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_rx_done && i_rx_data == SYNC_BYTE) begin
                        state   <= ST_OPCODE;
                        tmo_cnt <= '0;
                        o_busy  <= 1'b1;
                    end
                end
                ST_OPCODE, ST_OPER_A, ST_OPER_B: begin
                    // An expiring timeout takes priority over a byte arriving in the same cycle.
                    if (tmo_hit) begin
                        state    <= ST_IDLE;
                        byte_cnt <= '0;
                        o_err    <= 1'b1;
                        o_busy   <= 1'b0;
                    end else if (i_rx_done) begin
                        tmo_cnt <= '0;
                        if (state == ST_OPCODE) begin
                            o_alu_op <= i_rx_data[NB_ALU_OP-1:0];
                            byte_cnt <= '0;
                            state    <= ST_OPER_A;
                        end else begin
                            for (int i = 0; i < NBYTES; i++) begin
                                if (byte_cnt == NB_IDX'(i)) begin
                                    if (state == ST_OPER_A) o_alu_a[8*i +: 8] <= i_rx_data;
                                    else                    o_alu_b[8*i +: 8] <= i_rx_data;
                                end
                            end
                            if (byte_cnt == LAST_BYTE) begin
                                byte_cnt <= '0;
                                state    <= (state == ST_OPER_A) ? ST_OPER_B : ST_EXEC;
                            end else begin
                                byte_cnt <= byte_cnt + 1'b1;
                            end
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_EXEC: begin
                    res_q    <= i_alu_res;
                    res_ovf  <= i_alu_overflow;
                    res_zero <= i_alu_zero;
                    tx_idx   <= '0;
                    state    <= ST_SEND;
                end
                ST_SEND: begin
                    o_tx_data  <= tx_byte;
                    o_tx_start <= 1'b1;
                    state      <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (i_tx_done) begin
                        if (tx_idx == LAST_IDX) begin
                            state  <= ST_IDLE;
                            o_busy <= 1'b0;
                        end else begin
                            tx_idx <= tx_idx + 1'b1;
                            state  <= ST_SEND;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed bench for uart_alu_ctrl with a small ALU stub and a transmitter responder.
module tb_uart_alu_ctrl;

    localparam int TX_DLY = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        tx_done;
    logic [15:0] alu_res;
    logic        alu_ovf;
    logic        alu_zero;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [5:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        busy;
    logic        err;

    uart_alu_ctrl #(
        .NB_DATA(16), .NB_ALU_OP(6), .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYCLES(100), .NB_TIMEOUT(20)
    ) dut (
        .i_clk(clk), .i_reset(rst_n),
        .i_rx_data(rx_data), .i_rx_done(rx_done), .i_tx_done(tx_done),
        .i_alu_res(alu_res), .i_alu_overflow(alu_ovf), .i_alu_zero(alu_zero),
        .o_tx_start(tx_start), .o_tx_data(tx_data),
        .o_alu_op(alu_op), .o_alu_a(alu_a), .o_alu_b(alu_b),
        .o_busy(busy), .o_err(err)
    );

    always #10 clk = ~clk;

    // ALU stub: 0x20 ADD, 0x22 SUB, 0x24 AND; overflow is signed overflow.
    always_comb begin
        alu_res = 16'h0;
        alu_ovf = 1'b0;
        case (alu_op)
            6'h20: begin
                alu_res = alu_a + alu_b;
                alu_ovf = (alu_a[15] == alu_b[15]) && (alu_res[15] != alu_a[15]);
            end
            6'h22: begin
                alu_res = alu_a - alu_b;
                alu_ovf = (alu_a[15] != alu_b[15]) && (alu_res[15] != alu_a[15]);
            end
            6'h24: alu_res = alu_a & alu_b;
            default: ;
        endcase
        alu_zero = (alu_res == 16'h0);
    end

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_start = 0;
    int n_err = 0;
    int last_rx_cyc = 0;
    bit hold_chk_en = 1'b1;
    logic busy_after_done;
    logic [7:0] tx_hold;
    logic [7:0] tx_q[$];
    int start_cyc_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (tx_start) n_start++;
        if (err) n_err++;
    end

    // Transmitter model: accepts a request, holds for TX_DLY cycles, then pulses done.
    initial begin
        tx_done = 1'b0;
        busy_after_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                tx_hold = tx_data;
                tx_q.push_back(tx_data);
                start_cyc_q.push_back(cyc);
                repeat (TX_DLY) begin
                    @(negedge clk);
                    if (hold_chk_en) chk("tx_data_hold", 32'(tx_data), 32'(tx_hold));
                end
                tx_done = 1'b1;
                @(negedge clk);
                tx_done = 1'b0;
                busy_after_done = busy;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        last_rx_cyc = cyc;
        @(negedge clk);
        rx_done = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
        tx_q.delete();
        start_cyc_q.delete();
        send_byte(8'hA5);
        send_byte(op);
        send_byte(a[7:0]);
        send_byte(a[15:8]);
        send_byte(b[7:0]);
        send_byte(b[15:8]);
    endtask

    task automatic wait_idle(input int target);
        int n;
        n = 0;
        while ((n_start < target || busy) && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("resp_in_time", 32'(n < 600), 32'd1);
        @(negedge clk);
    endtask

    task automatic check_resp(input logic [7:0] st, input logic [15:0] res);
        logic [7:0] exp_b[3];
        logic [7:0] act;
        exp_b[0] = st;
        exp_b[1] = res[7:0];
        exp_b[2] = res[15:8];
        chk("tx_count", 32'(tx_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            act = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
            chk("tx_byte", 32'(act), 32'(exp_b[i]));
        end
        chk("busy_after_last_done", 32'(busy_after_done), 32'd0);
    endtask

    typedef struct {
        logic [7:0]  op_byte;
        logic [15:0] a;
        logic [15:0] b;
        logic [5:0]  exp_op;
        logic [7:0]  exp_status;
        logic [15:0] exp_res;
    } vec_t;

    vec_t vecs[6];
    int base;

    initial begin
        vecs[0] = '{8'h20, 16'h1234, 16'h0001, 6'h20, 8'h00, 16'h1235};
        vecs[1] = '{8'h22, 16'h0005, 16'h0005, 6'h22, 8'h01, 16'h0000};
        vecs[2] = '{8'h20, 16'h7FFF, 16'h0001, 6'h20, 8'h02, 16'h8000};
        vecs[3] = '{8'hE4, 16'hF0F0, 16'h0FF0, 6'h24, 8'h00, 16'h00F0};
        vecs[4] = '{8'h20, 16'hA5A5, 16'h0000, 6'h20, 8'h00, 16'hA5A5};
        vecs[5] = '{8'h22, 16'h8000, 16'h0001, 6'h22, 8'h02, 16'h7FFF};

        rst_n = 1'b0;
        rx_data = 8'h0;
        rx_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        for (int v = 0; v < 6; v++) begin
            base = n_start;
            send_frame(vecs[v].op_byte, vecs[v].a, vecs[v].b);
            wait_idle(base + 3);
            chk("alu_op", 32'(alu_op), 32'(vecs[v].exp_op));
            chk("alu_a", 32'(alu_a), 32'(vecs[v].a));
            chk("alu_b", 32'(alu_b), 32'(vecs[v].b));
            chk("start_pulses", 32'(n_start - base), 32'd3);
            check_resp(vecs[v].exp_status, vecs[v].exp_res);
            if (v == 0) begin
                chk("first_start_latency", 32'(start_cyc_q.size() > 0 ? start_cyc_q[0] - last_rx_cyc : -1), 32'd3);
                chk("start_spacing", 32'(start_cyc_q.size() > 1 ? start_cyc_q[1] - start_cyc_q[0] : -1), 32'(TX_DLY + 2));
            end
        end

        // Leading junk before the sync byte is dropped.
        base = n_start;
        send_byte(8'h00);
        send_byte(8'hFF);
        chk("junk_busy", 32'(busy), 32'd0);
        send_frame(8'h20, 16'h0001, 16'h0002);
        wait_idle(base + 3);
        check_resp(8'h00, 16'h0003);

        // Inter-byte timeout after a partial frame.
        base = n_start;
        n_err = 0;
        send_byte(8'hA5);
        send_byte(8'h20);
        send_byte(8'h34);
        repeat (90) @(negedge clk);
        chk("tmo_not_yet_busy", 32'(busy), 32'd1);
        chk("tmo_not_yet_err", 32'(n_err), 32'd0);
        repeat (60) @(negedge clk);
        chk("tmo_err_cycles", 32'(n_err), 32'd1);
        chk("tmo_no_start", 32'(n_start - base), 32'd0);
        chk("tmo_busy", 32'(busy), 32'd0);
        chk("tmo_partial_op", 32'(alu_op), 32'h20);
        chk("tmo_partial_a_lo", 32'(alu_a[7:0]), 32'h34);
        send_frame(8'h20, 16'h0002, 16'h0003);
        wait_idle(base + 3);
        check_resp(8'h00, 16'h0005);

        // Bytes arriving while the response is transmitted are lost.
        base = n_start;
        send_frame(8'h20, 16'h1111, 16'h2222);
        for (int n = 0; n < 100 && n_start < base + 1; n++) @(negedge clk);
        send_byte(8'hA5);
        send_byte(8'h20);
        wait_idle(base + 3);
        check_resp(8'h00, 16'h3333);
        chk("inject_a", 32'(alu_a), 32'h1111);
        chk("inject_b", 32'(alu_b), 32'h2222);
        repeat (10) @(negedge clk);
        chk("inject_no_frame", 32'(busy), 32'd0);

        // Reset during the second response byte.
        base = n_start;
        send_frame(8'h22, 16'h0010, 16'h0003);
        for (int n = 0; n < 200 && n_start < base + 2; n++) @(negedge clk);
        chk("rst_reached_byte2", 32'(n_start - base), 32'd2);
        hold_chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx_start", 32'(tx_start), 32'd0);
        chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
        chk("mid_rst_alu_op", 32'(alu_op), 32'd0);
        chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
        chk("mid_rst_alu_b", 32'(alu_b), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("post_rst_no_start", 32'(n_start - base), 32'd2);
        hold_chk_en = 1'b1;
        base = n_start;
        send_frame(8'h20, 16'h0100, 16'h0200);
        wait_idle(base + 3);
        check_resp(8'h00, 16'h0300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1, "bench timeout");
    end

endmodule
